// File: rtl/damage_sequencer.sv
// damage_sequencer: control FSM in front of the Meowth damage datapath.
// Sequences HP load, damage calc, x-decrement and white-pixel draw for each
// attack request, watches the datapath handshakes with a timeout, and reports
// turn completion or battle end back to the battle controller.
// Optional build macro: DAMAGE_QUEUE_EN adds a one-deep pending-attack latch
// so an attack_go seen while busy starts the next turn straight after DONE.
module damage_sequencer #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd400000,
  parameter int          HIT_W          = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_attack_go,
  input  logic             i_done_decrement,
  input  logic             i_done_damage,
  input  logic             i_game_over,
  output logic             o_enable_HP_calc,
  output logic             o_enable_DMG_calc,
  output logic             o_enable_decrement_control,
  output logic             o_enable_draw_decrease,
  output logic             o_plot,
  output logic             o_busy,
  output logic             o_turn_done,
  output logic             o_battle_over,
  output logic             o_fault,
  output logic [HIT_W-1:0] o_hits_taken
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_SETTLE,
    S_DECREMENT,
    S_DRAW,
    S_CHECK,
    S_DONE,
    S_OVER
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [19:0]      r_timer;
  logic             r_fault;
  logic [HIT_W-1:0] r_hits;
  logic             w_timeout;
  logic             w_busy;

  // A wait state gives up only when its own done input is still low on the
  // last allowed cycle, so a late done always beats the timeout.
  assign w_timeout = (r_timer == (TIMEOUT_CYCLES - 20'd1)) &&
                     (((r_state == S_DECREMENT) && !i_done_decrement) ||
                      ((r_state == S_DRAW) && !i_done_damage));

  assign w_busy = (r_state != S_IDLE) && (r_state != S_OVER);

`ifdef DAMAGE_QUEUE_EN
  logic r_pending;
  logic w_startNext;

  // A request arriving in DONE itself counts as queued, otherwise it would be lost.
  assign w_startNext = r_pending || i_attack_go;

  // Pending latch: hold one attack seen while busy, drop extras, clear on use or battle end.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pending <= 1'b0;
    end else if (w_nextState == S_OVER) begin
      r_pending <= 1'b0;
    end else if ((r_state == S_DONE) && (w_nextState == S_LOAD)) begin
      r_pending <= 1'b0;
    end else if (w_busy && i_attack_go) begin
      r_pending <= 1'b1;
    end
  end
`else
  logic w_startNext;

  assign w_startNext = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic for the attack sequence.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_attack_go) begin
          w_nextState = S_LOAD;
        end
      end
      S_LOAD:   w_nextState = S_CALC;
      S_CALC:   w_nextState = S_SETTLE;
      S_SETTLE: w_nextState = S_DECREMENT;
      S_DECREMENT: begin
        if (i_done_decrement) begin
          w_nextState = S_DRAW;
        end else if (w_timeout) begin
          w_nextState = S_DONE;
        end
      end
      S_DRAW: begin
        if (i_done_damage) begin
          w_nextState = S_CHECK;
        end else if (w_timeout) begin
          w_nextState = S_DONE;
        end
      end
      S_CHECK: begin
        if (i_game_over) begin
          w_nextState = S_OVER;
        end else begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        if (w_startNext) begin
          w_nextState = S_LOAD;
        end else begin
          w_nextState = S_IDLE;
        end
      end
      S_OVER:  w_nextState = S_OVER;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Wait timer: restarts on every state change so each wait state gets a fresh budget.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_timer <= 20'd0;
    end else if (w_nextState != r_state) begin
      r_timer <= 20'd0;
    end else if ((r_state == S_DECREMENT) || (r_state == S_DRAW)) begin
      r_timer <= r_timer + 20'd1;
    end
  end

  // Sticky fault flag, set by any wait-state timeout.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_fault <= 1'b0;
    end else if (w_timeout) begin
      r_fault <= 1'b1;
    end
  end

  // Hit counter: counts hits that reached CHECK, saturating instead of wrapping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_hits <= '0;
    end else if ((r_state == S_CHECK) && (r_hits != {HIT_W{1'b1}})) begin
      r_hits <= r_hits + HIT_W'(1);
    end
  end

  // Moore output decode from the current state.
  always_comb begin
    o_enable_HP_calc           = 1'b0;
    o_enable_DMG_calc          = 1'b0;
    o_enable_decrement_control = 1'b0;
    o_enable_draw_decrease     = 1'b0;
    o_turn_done                = 1'b0;
    o_battle_over              = 1'b0;
    case (r_state)
      S_LOAD:      o_enable_HP_calc           = 1'b1;
      S_CALC:      o_enable_DMG_calc          = 1'b1;
      S_DECREMENT: o_enable_decrement_control = 1'b1;
      S_DRAW:      o_enable_draw_decrease     = 1'b1;
      S_DONE:      o_turn_done                = 1'b1;
      S_OVER:      o_battle_over              = 1'b1;
      default: begin
      end
    endcase
  end

  assign o_plot       = o_enable_draw_decrease;
  assign o_busy       = w_busy;
  assign o_fault      = r_fault | w_timeout;
  assign o_hits_taken = r_hits;

endmodule
